wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
Write-domain pointer and full-flag generator for the asynchronous FIFO. It is the consumer of the synchronized read pointer (wq2_rptr) produced by the read-to-write synchronizer. It also produces the Gray-coded write pointer that the read side synchronizes.
It advances the write pointer, drives the RAM write address, and generates registered full, almost-full, fill-level and sticky overflow indications, all in the wclk domain.

Parameters:
ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE; must be >= 2
AFULL_THRESH, 14, walmost_full asserts when computed level >= this value; legal range 1..2**ADDRSIZE

Ports:
wclk  input  1  write-domain clock, rising edge
wrst  input  1  asynchronous, active-high reset
winc  input  1  write request; a write is accepted only when wfull=0
wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already 2-flop synchronized into wclk
wclr_ovf  input  1  synchronous clear of woverflow
waddr  output  ADDRSIZE  binary RAM write address (low bits of binary write pointer)
wptr  output  ADDRSIZE+1  registered Gray write pointer, to be synchronized into the read domain
wfull  output  1  registered full flag
walmost_full  output  1  registered almost-full flag
wlevel  output  ADDRSIZE+1  registered fill level as seen from the write domain, 0..2**ADDRSIZE
woverflow  output  1  sticky: write attempted while full

Behaviour:
- Reset (wrst=1, async): binary pointer wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. Outputs update immediately on assertion; registers resume on the first wclk edge after deassertion.
- Write accept: wen = winc & ~wfull.
- Next pointer: wbinnext = wbin + wen, modulo 2**(ADDRSIZE+1). wgraynext = (wbinnext >> 1) ^ wbinnext.
- On each wclk edge, wbin <= wbinnext and wptr <= wgraynext.
- waddr = wbin[ADDRSIZE-1:0], combinational from the register. The RAM writes mem[waddr] in the same cycle that wen=1.
- Full: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}). Full therefore asserts on the same edge that accepts the write filling the last slot, with zero-cycle lag.
- Read-pointer conversion: rbin_s = Gray-to-binary of wq2_rptr (XOR-prefix from the MSB), combinational.
- Level: wlevel <= wbinnext - rbin_s, modulo 2**(ADDRSIZE+1). The maximum value 2**ADDRSIZE coincides with wfull=1.
- Almost-full: walmost_full <= ((wbinnext - rbin_s) >= AFULL_THRESH).
- Pessimism: because wq2_rptr is 2+ cycles stale, wlevel and both flags may over-report fullness but never under-report it.
- Deassertion timing: wfull, walmost_full and wlevel deassert/decrease only on the first wclk edge after wq2_rptr changes.
- Overflow: woverflow <= (woverflow & ~wclr_ovf) | (winc & wfull). If a set and wclr_ovf occur in the same cycle, the set wins.
- Write while full: wbin, wptr and waddr hold; no RAM write occurs.
- Wrap-around: the pointer MSB toggles every 2**ADDRSIZE writes. The full compare and the level arithmetic stay correct across wrap because they are modulo 2**(ADDRSIZE+1).
- Simultaneous winc and wq2_rptr change: next-cycle flags use the new wq2_rptr and the post-write pointer together.
- Mid-operation reset: all state returns to reset values at once. The read side must be reset concurrently; no recovery is attempted otherwise.
- wptr is a direct register output with no combinational logic after it. This is mandatory for CDC safety.

Test Plan:
1. Reset, then 16 consecutive winc=1 with wq2_rptr=5'h00 -> wptr steps 01,03,02,06,... and reaches 5'h18 after the 16th write; wfull=1 on that same edge; wlevel=16; walmost_full=1 from the edge where the level reaches 14.
2. Full state, then winc=1 for 3 cycles -> wptr holds at 5'h18, waddr holds at 0, woverflow=1 and stays 1; a wclr_ovf pulse with winc=0 clears it next edge; wclr_ovf and winc=1 together while full -> woverflow stays 1.
3. Full state, then wq2_rptr set to 5'h06 (binary 4) -> next edge: wfull=0, wlevel=12, walmost_full=0.
4. Wrap: 40 writes with wq2_rptr following wptr at 2-cycle delay -> wfull never asserts; wptr MSB toggles after write 16 and write 32; wlevel stays at 2 or less.
5. Threshold: AFULL_THRESH=8, wq2_rptr=0 -> walmost_full rises exactly on the edge accepting the 8th write; wfull stays 0.
6. Assert wrst mid-fill (level 9) asynchronously between clock edges -> all outputs read 0 before the next wclk edge; the first write after release produces wptr=5'h01 and waddr=0.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full flags, fill level and sticky overflow
// for the asynchronous FIFO; wptr leaves straight from a register for the CDC path.
module wptr_full_ctrl #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wclr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic              wen;
  logic              full_next;
  logic              afull_next;

  assign wen       = winc & ~wfull;
  assign wbinnext  = wbin + (ADDRSIZE+1)'(wen);
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;
  assign waddr     = wbin[ADDRSIZE-1:0];

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  assign level_next = wbinnext - rbin_s;
  assign afull_next = (level_next >= AFULL_LVL);
  assign full_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
      // A new overflow outranks a clear arriving in the same cycle.
      woverflow    <= (woverflow & ~wclr_ovf) | (winc & wfull);
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed and randomized bench for wptr_full_ctrl against a write/read-count model.
module tb_wptr_full_ctrl;

  localparam int DEPTH = 16;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic       wclr_ovf = 1'b0;
  logic [4:0] wq2_rptr = '0;

  logic [3:0] waddr, waddr8;
  logic [4:0] wptr, wptr8, wlevel, wlevel8;
  logic       wfull, wfull8, walmost_full, walmost_full8, woverflow, woverflow8;

  int checks = 0;
  int failures = 0;

  // model state: total accepted writes and total reads reflected in wq2_rptr
  int wcount = 0;
  int rcount = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_ovf = 0;

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_THRESH(14)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wclr_ovf(wclr_ovf),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow)
  );

  wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_THRESH(8)) dut_t8 (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wclr_ovf(wclr_ovf),
    .waddr(waddr8), .wptr(wptr8), .wfull(wfull8), .walmost_full(walmost_full8),
    .wlevel(wlevel8), .woverflow(woverflow8)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ":wptr"}, 32'(wptr), 32'(gray(wcount % 32)));
    check({ctx, ":waddr"}, 32'(waddr), 32'(wcount % DEPTH));
    check({ctx, ":wfull"}, 32'(wfull), 32'(m_full));
    check({ctx, ":wlevel"}, 32'(wlevel), 32'(m_level));
    check({ctx, ":afull14"}, 32'(walmost_full), 32'(m_level >= 14));
    check({ctx, ":woverflow"}, 32'(woverflow), 32'(m_ovf));
    check({ctx, ":afull8"}, 32'(walmost_full8), 32'(m_level >= 8));
    check({ctx, ":wptr_t8"}, 32'(wptr8), 32'(gray(wcount % 32)));
  endtask

  task automatic step(input bit inc, input bit clr, input int new_rcount);
    bit accept;
    winc = inc;
    wclr_ovf = clr;
    rcount = new_rcount;
    wq2_rptr = gray(rcount % 32);
    @(posedge wclk);
    accept = inc && !m_full;
    m_ovf = (m_ovf && !clr) || (inc && m_full);
    if (accept) wcount++;
    m_level = wcount - rcount;
    m_full = (m_level == DEPTH);
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    winc = 1'b0;
    wclr_ovf = 1'b0;
    wcount = 0;
    rcount = 0;
    m_level = 0;
    m_full = 0;
    m_ovf = 0;
    wq2_rptr = '0;
    #1;
    check_all("reset");
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  initial begin
    // 1: fill from empty
    #1;
    check_all("por");
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0);
      if (i == 13) check("fill13_afull", 32'(walmost_full), 32'd0);
      if (i == 14) check("fill14_afull", 32'(walmost_full), 32'd1);
    end
    check("fill_wptr18", 32'(wptr), 32'h18);
    check("fill_full", 32'(wfull), 32'd1);
    check("fill_level16", 32'(wlevel), 32'd16);

    // 2: writes while full, overflow set/clear
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("ovf_wptr_hold", 32'(wptr), 32'h18);
    check("ovf_waddr_hold", 32'(waddr), 32'd0);
    check("ovf_set", 32'(woverflow), 32'd1);
    step(0, 1, 0);
    check("ovf_clr", 32'(woverflow), 32'd0);
    step(1, 1, 0);
    check("ovf_set_wins", 32'(woverflow), 32'd1);

    // 3: read pointer advances to 4
    step(0, 0, 4);
    check("drain_full", 32'(wfull), 32'd0);
    check("drain_level", 32'(wlevel), 32'd12);
    check("drain_afull", 32'(walmost_full), 32'd0);

    // 4: wrap with trailing read pointer
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, (wcount > 0) ? wcount - 1 : 0);
      check("wrap_level_le2", 32'(wlevel <= 5'd2), 32'd1);
      if (i == 16) check("wrap_msb16", 32'(wptr[4]), 32'd1);
      if (i == 32) check("wrap_msb32", 32'(wptr[4]), 32'd0);
    end

    // 5: threshold 8 instance
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0);
      if (i == 7) check("t8_afull7", 32'(walmost_full8), 32'd0);
    end
    check("t8_afull8", 32'(walmost_full8), 32'd1);
    check("t8_full", 32'(wfull8), 32'd0);

    // 6: asynchronous reset mid-fill
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 1, 0);
    check("pre_rst_level9", 32'(wlevel), 32'd9);
    #2;
    do_reset();
    check("rst_wptr0", 32'(wptr), 32'd0);
    check("rst_level0", 32'(wlevel), 32'd0);
    check("post_rst_waddr0", 32'(waddr), 32'd0);
    step(1, 0, 0);
    check("post_rst_wptr01", 32'(wptr), 32'h01);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int nr;
      nr = rcount;
      if ($urandom_range(0, 2) == 0) nr = rcount + int'($urandom_range(0, wcount - rcount));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, nr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
